// File: rtl/imem_responder.sv
// Byte-addressable Y86-64 instruction memory answering 10-byte fetch windows over valid/ready.
// Serial 10-cycle fetch by default; define IMEM_FAST_EN to read the whole window at the accept edge.
module imem_responder #(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [79:0]       resp_inst,
  output logic              resp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data
);

  localparam int                IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [79:0]         inst_q, inst_d;
  logic                err_q, err_d;

  logic [7:0]          mem_q [MEM_BYTES];

  // Bytes past the top of memory read as zero; the sum is never wrapped.
  function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a);
    logic [7:0] b;
    b = 8'h00;
    if (a < LIMIT) b = mem_q[a[IDX_W-1:0]];
    return b;
  endfunction

  // The read path samples mem_q before this edge, so a same-cycle write yields the old byte.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < LIMIT)) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          inst_d = '0;
          err_d  = 1'b0;
          cnt_d  = 4'd0;
          if (req_addr >= LIMIT) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
`ifdef IMEM_FAST_EN
            for (int k = 0; k < 10; k++) begin
              inst_d[8*k +: 8] = rd_byte(req_addr + ADDR_W'(k));
            end
            state_d = RESP;
`else
            state_d = FETCH;
`endif
          end
        end
      end
      FETCH: begin
        inst_d[8*int'(cnt_q) +: 8] = rd_byte(addr_q + ADDR_W'(cnt_q));
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_inst  = inst_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: expected windows are queued at request time, popped at response.
module tb_imem_responder;

  localparam int MEM_BYTES = 2048;
  localparam int ADDR_W    = 64;
`ifdef IMEM_FAST_EN
  localparam int FETCH_LAT = 0;
`else
  localparam int FETCH_LAT = 10;
`endif

  typedef struct {
    logic [79:0] inst;
    logic        err;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [79:0]       resp_inst;
  logic              resp_err;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  logic [7:0] model [MEM_BYTES];

  imem_responder #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven and outputs sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (a < MEM_BYTES) model[a[10:0]] = d;
  endtask

  function automatic exp_t window(input logic [ADDR_W-1:0] a);
    exp_t e;
    logic [ADDR_W-1:0] b;
    e.inst = '0;
    e.err  = 1'b0;
    if (a >= MEM_BYTES) begin
      e.err = 1'b1;
    end else begin
      for (int k = 0; k < 10; k++) begin
        b = a + ADDR_W'(k);
        if (b < MEM_BYTES) e.inst[8*k +: 8] = model[b[10:0]];
      end
    end
    return e;
  endfunction

  // Presents a request for one cycle; the caller issues only while req_ready is high.
  task automatic issue(input logic [ADDR_W-1:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  // Edges counted after the accept edge until resp_valid; -1 when the budget runs out.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b want=0", resp_err); end
    n_checks++;
    if (resp_inst !== 80'h0) begin n_fail++; $display("FAIL reset_resp_inst got=%h want=0", resp_inst); end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    bit seen;
    issue(64'd0);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_resp_valid got=%b want=0", resp_valid); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready got=%b want=1", req_ready); end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_orphan_resp got=%b want=0", seen); end
  endtask

  task automatic test_basic_fetch();
    exp_t e, got;
    int   lat;
    e.inst = 80'h0000_0000_0000_000A_F330;
    e.err  = 1'b0;
    sb_q.push_back(e);
    issue(64'd0);
    wait_resp(lat);
    n_checks++;
    if (lat != FETCH_LAT) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, FETCH_LAT); end
    got = sb_q.pop_front();
    n_checks++;
    if (resp_inst !== got.inst) begin n_fail++; $display("FAIL basic_inst got=%h want=%h", resp_inst, got.inst); end
    n_checks++;
    if (resp_err !== got.err) begin n_fail++; $display("FAIL basic_err got=%b want=%b", resp_err, got.err); end
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_handshake valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    int   bad;
    resp_ready = 1'b0;
    sb_q.push_back(window(64'd3));
    issue(64'd3);
    wait_resp(lat);
    e   = sb_q.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid !== 1'b1 || resp_inst !== e.inst || req_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (lat != FETCH_LAT || bad != 0) begin
      n_fail++; $display("FAIL backpressure_hold lat=%0d bad_cycles=%0d inst=%h want lat=%0d bad_cycles=0 inst=%h",
                         lat, bad, resp_inst, FETCH_LAT, e.inst);
    end
    resp_ready = 1'b1;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL backpressure_release valid=%b ready=%b want valid=0 ready=1", resp_valid, req_ready);
    end
  endtask

  task automatic test_out_of_range();
    logic [ADDR_W-1:0] addrs [2];
    exp_t e;
    int   lat;
    addrs[0] = 64'd2048;
    addrs[1] = 64'h8000_0000_0000_0000;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(window(addrs[i]));
      issue(addrs[i]);
      wait_resp(lat);
      e = sb_q.pop_front();
      n_checks++;
      if (lat != 0) begin n_fail++; $display("FAIL oor_latency[%0d] got=%0d want=0", i, lat); end
      n_checks++;
      if (resp_err !== e.err || resp_inst !== e.inst) begin
        n_fail++; $display("FAIL oor_resp[%0d] err=%b inst=%h want err=%b inst=%h", i, resp_err, resp_inst, e.err, e.inst);
      end
      tick();
    end
  endtask

  task automatic test_top_window();
    exp_t e;
    int   lat;
    write_byte(64'd2046, 8'h10);
    write_byte(64'd2047, 8'h00);
    write_byte(64'd2048, 8'h55);
    sb_q.push_back(window(64'd2046));
    issue(64'd2046);
    wait_resp(lat);
    e = sb_q.pop_front();
    n_checks++;
    if (resp_inst !== e.inst || e.inst !== 80'h0010) begin
      n_fail++; $display("FAIL top_window_inst got=%h want=%h", resp_inst, 80'h0010);
    end
    n_checks++;
    if (resp_err !== 1'b0) begin n_fail++; $display("FAIL top_window_err got=%b want=0", resp_err); end
    tick();
  endtask

  task automatic test_write_during_fetch();
    exp_t e, got;
    int   lat;
    e = window(64'd0);
    e.inst[79:72] = 8'hBB;
    sb_q.push_back(e);
    issue(64'd0);
`ifdef IMEM_FAST_EN
    // Whole window already captured at accept; late writes must not disturb it.
    e.inst[79:72] = model[9];
    sb_q.pop_back();
    sb_q.push_back(e);
    write_byte(64'd5, 8'hAA);
    write_byte(64'd9, 8'hBB);
`else
    for (int i = 0; i < 5; i++) tick();
    write_byte(64'd5, 8'hAA);
    tick();
    write_byte(64'd9, 8'hBB);
`endif
    resp_ready = 1'b0;
    wait_resp(lat);
    got = sb_q.pop_front();
    n_checks++;
    if (resp_inst !== got.inst) begin n_fail++; $display("FAIL wr_during_fetch_inst got=%h want=%h", resp_inst, got.inst); end
    resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] addrs [3];
    exp_t e;
    int   lat;
    int   bad;
    addrs[0] = 64'd1;
    addrs[1] = 64'd5;
    addrs[2] = 64'd2040;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(window(addrs[i]));
      issue(addrs[i]);
      wait_resp(lat);
      e = sb_q.pop_front();
      if (lat != FETCH_LAT || resp_inst !== e.inst || resp_err !== e.err) bad++;
      tick();
      if (req_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL back_to_back bad=%0d want=0", bad); end
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size()); end
  endtask

  initial begin
    logic [7:0] prog [16];
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;

    test_reset();

    prog = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h61, 8'h23, 8'h70, 8'h44, 8'h00, 8'h90};
    for (int i = 0; i < 16; i++) write_byte(ADDR_W'(i), prog[i]);
    for (int i = 2040; i < 2046; i++) write_byte(ADDR_W'(i), 8'(i * 7));

    test_reset_mid_fetch();
    test_basic_fetch();
    test_backpressure();
    test_out_of_range();
    test_top_window();
    test_write_during_fetch();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
